// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
// booth_pkg : shared FSM encoding for the sequential Booth multiplier
// Rev 1.0
// ============================================================================
package booth_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : booth_pkg
`default_nettype wire

// File: rtl/booth_seq_mult_if.sv
`default_nettype none
// ============================================================================
// booth_seq_mult_if : start/done handshake and operand/product bus
// Rev 1.0
// ============================================================================
interface booth_seq_mult_if #(
    parameter int N = 4
);
    logic             start;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic             busy;
    logic             done;
    logic [2*N-1:0]   p;

    modport master (
        output start, a, b,
        input  busy, done, p
    );

    modport slave (
        input  start, a, b,
        output busy, done, p
    );
endinterface : booth_seq_mult_if
`default_nettype wire

// File: rtl/n_full_adder_one.sv
`default_nettype none
// ============================================================================
// n_full_adder_one : N-bit ripple add/subtract cell, S = A + (B ^ k) + k
// Rev 1.0
// ============================================================================
module n_full_adder_one #(
    parameter int N = 4
) (
    input  wire logic [N-1:0] A,
    input  wire logic [N-1:0] B,
    input  wire logic         k,
    output logic      [N-1:0] S
);
    logic [N-1:0] carry;
    logic [N-1:0] b_x;

    assign carry[0] = k;

    generate
        for (genvar i = 0; i < N; i++) begin : g_bit
            assign b_x[i] = B[i] ^ k;
            assign S[i]   = A[i] ^ b_x[i] ^ carry[i];
            // Carry out of the top bit is discarded; the caller sizes A/B so it never matters.
            if (i < N - 1) begin : g_carry
                assign carry[i+1] = (A[i] & b_x[i]) | (carry[i] & (A[i] ^ b_x[i]));
            end
        end
    endgenerate

endmodule : n_full_adder_one
`default_nettype wire

// File: rtl/booth_seq_mult.sv
`default_nettype none
// ============================================================================
// booth_seq_mult : sequential signed radix-2 Booth multiplier, 2N-bit product
// Rev 1.0
// ============================================================================
module booth_seq_mult
    import booth_pkg::*;
#(
    parameter int N = 4
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    booth_seq_mult_if.slave bus
);
    localparam int CNT_W = $clog2(N + 1);

    state_e           state_q, state_d;
    logic [N-1:0]     m_q, m_d;
    logic [N:0]       acc_q, acc_d;
    logic [N-1:0]     q_q, q_d;
    logic             q1_q, q1_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*N-1:0]   p_q, p_d;

    logic [N:0]       m_ext;
    logic             sub_sel;
    logic [N:0]       sum;
    logic [N:0]       acc_sel;
    logic [N:0]       acc_sh;
    logic [N-1:0]     q_sh;
    logic             last_iter;

    assign m_ext   = {m_q[N-1], m_q};
    assign sub_sel = q_q[0] & ~q1_q;

    n_full_adder_one #(
        .N (N + 1)
    ) u_add (
        .A (acc_q),
        .B (m_ext),
        .k (sub_sel),
        .S (sum)
    );

    // Pairs 00/11 leave the accumulator untouched.
    assign acc_sel   = (q_q[0] ^ q1_q) ? sum : acc_q;
    assign acc_sh    = {acc_sel[N], acc_sel[N:1]};
    assign q_sh      = {acc_sel[0], q_q[N-1:1]};
    assign last_iter = (cnt_q == CNT_W'(N - 1));

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        q1_d    = q1_q;
        cnt_d   = cnt_q;
        p_d     = p_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d = ST_CALC;
                    m_d     = bus.a;
                    acc_d   = '0;
                    q_d     = bus.b;
                    q1_d    = 1'b0;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                acc_d = acc_sh;
                q_d   = q_sh;
                q1_d  = q_q[0];
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    state_d = ST_DONE;
                    p_d     = {acc_sh[N-1:0], q_sh};
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    assign bus.busy = (state_q == ST_CALC);
    assign bus.done = (state_q == ST_DONE);
    assign bus.p    = p_q;

endmodule : booth_seq_mult
`default_nettype wire

// File: tb/tb_booth_seq_mult.sv
`default_nettype none
// ============================================================================
// tb_booth_seq_mult : directed-vector and sweep bench for booth_seq_mult (N=4)
// Rev 1.0
// ============================================================================
module tb_booth_seq_mult;

    localparam int N     = 4;
    localparam int LIMIT = 20;

    typedef struct {
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [2*N-1:0] exp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    booth_seq_mult_if #(.N(N)) bus ();

    booth_seq_mult #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for done after an accept edge; returns edges elapsed and busy cycles seen.
    task automatic wait_done(output int edges, output int busy_cnt);
        edges    = 0;
        busy_cnt = 0;
        while (!bus.done && edges < LIMIT) begin
            if (bus.busy) busy_cnt++;
            tick();
            edges++;
        end
    endtask

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          output logic [2*N-1:0] p, output int edges,
                          output int busy_cnt, output logic extra_done);
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(edges, busy_cnt);
        p = bus.p;
        tick();
        extra_done = bus.done;
    endtask

    initial begin
        vec_t           vecs [8];
        logic [2*N-1:0] p;
        int             edges;
        int             busy_cnt;
        logic           extra;

        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        vecs[0] = '{a: 4'd3,  b: 4'd5,  exp: 8'h0F};
        vecs[1] = '{a: 4'h8,  b: 4'h8,  exp: 8'h40};
        vecs[2] = '{a: 4'd7,  b: 4'h8,  exp: 8'hC8};
        vecs[3] = '{a: 4'hF,  b: 4'd1,  exp: 8'hFF};
        vecs[4] = '{a: 4'h8,  b: 4'd7,  exp: 8'hC8};
        vecs[5] = '{a: 4'd0,  b: 4'h8,  exp: 8'h00};
        vecs[6] = '{a: 4'h9,  b: 4'h9,  exp: 8'h31};
        vecs[7] = '{a: 4'd6,  b: 4'hD,  exp: 8'hEE};

        tick();
        tick();
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_p",    32'(bus.p),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, p, edges, busy_cnt, extra);
            check($sformatf("vec%0d_p", i),       32'(p),        32'(vecs[i].exp));
            check($sformatf("vec%0d_latency", i), 32'(edges),    32'(N));
            check($sformatf("vec%0d_busy", i),    32'(busy_cnt), 32'(N));
            check($sformatf("vec%0d_done1", i),   32'(extra),    32'd0);
        end

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                logic signed [N-1:0] sa;
                logic signed [N-1:0] sb;
                int                  prod;
                sa   = 4'(i);
                sb   = 4'(j);
                prod = int'(sa) * int'(sb);
                run_op(sa, sb, p, edges, busy_cnt, extra);
                check($sformatf("sweep_%0d_%0d_p", i, j), 32'(p), 32'(prod[2*N-1:0]));
                if (edges != N || extra)
                    check($sformatf("sweep_%0d_%0d_onedone", i, j),
                          {24'd0, 4'(edges), 3'd0, extra}, {24'd0, 4'(N), 4'd0});
            end
        end

        // Start while busy is ignored and operands are not re-sampled.
        bus.a = 4'd2; bus.b = 4'd3; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.a = 4'd5; bus.b = 4'd5; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(edges, busy_cnt);
        check("ignore_latency", 32'(edges + 2), 32'(N));
        check("ignore_p",       32'(bus.p),     32'h06);
        tick();
        check("ignore_no_second", 32'(bus.busy | bus.done), 32'd0);
        tick();

        // Back-to-back: start re-asserted in the DONE cycle.
        bus.a = 4'd2; bus.b = 4'd3; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(edges, busy_cnt);
        check("b2b_first_p", 32'(bus.p), 32'h06);
        bus.a = 4'hD; bus.b = 4'd4; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(edges, busy_cnt);
        check("b2b_gap",      32'(edges + 1), 32'(N + 1));
        check("b2b_second_p", 32'(bus.p),     32'hF4);
        tick();

        // Reset mid-operation aborts.
        bus.a = 4'd7; bus.b = 4'd7; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_p",    32'(bus.p),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        edges = 0;
        while (!bus.done && edges < 3) begin
            tick();
            edges++;
        end
        check("abort_no_done", 32'(bus.done), 32'd0);
        run_op(4'hB, 4'd3, p, edges, busy_cnt, extra);
        check("post_reset_p",       32'(p),     32'hF1);
        check("post_reset_latency", 32'(edges), 32'(N));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_booth_seq_mult
`default_nettype wire
